multichannel_magnitude_accel: RTL
=================================

MULTICHANNEL_MAGNITUDE_ACCEL -- requirements
Module: multichannel_magnitude_accel

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of channel buffers summed per block (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 32, signed sample width in the low bits of each read word (8..32).
REQ-003 SHALL have parameter ACC_W, default 64, accumulator width, written as two 32-bit words.
REQ-004 SHALL have parameter AVS_ADDR_W, default 4, and AVM_ADDR_W, default 32; both data widths fixed at 32.
REQ-005 SHALL use one clock, csi_clock_clk; reset is csi_clock_reset_n, synchronous and active-high (1 = reset).
REQ-006 csi_clock_clk  in  1  sole clock, all logic on rising edge.
REQ-007 csi_clock_reset_n  in  1  synchronous active-high reset.
REQ-008 avs_avalonslave_address/read/write/writedata/readdata  in/in/in/in/out  AVS_ADDR_W/1/1/32/32  control slave, read latency 1.
REQ-009 avm_avalonmaster_address/read/write/writedata  out  AVM_ADDR_W/1/1/32  data master, word addresses.
REQ-010 avm_avalonmaster_waitrequest/readdata  in  1/32  master handshake; readdata valid in the cycle waitrequest is low during read.
REQ-011 DONE  out  1  high from job completion until next start or reset.

Function
REQ-012 Slave map (word offsets) SHALL be: 0 CTRL (w: bit0 start, bit1 mode, bit2 abort), 1 STATUS (r: done, busy, ovf, aborted, cfg_err in bits 0-4), 2 SRC_BASE, 3 CH_STRIDE, 4 DST_BASE, 5 BLOCK_LEN, 6 BLOCK_CNT, 7 BLOCKS_DONE (r).
REQ-013 Config registers SHALL be latched into working copies on start; writes while busy SHALL affect only the next job.
REQ-014 Start while busy SHALL be ignored; start from IDLE or DONE SHALL clear DONE, ovf, aborted, cfg_err, BLOCKS_DONE.
REQ-015 FSM states SHALL be IDLE, READ, ACC, WR_LO, WR_HI, DONE.
REQ-016 Sample address for block b, sample i, channel c SHALL be SRC_BASE + c*CH_STRIDE + b*BLOCK_LEN + i; read order c-fastest, then i.
REQ-017 READ SHALL hold address and read high until waitrequest low, then capture readdata[SAMPLE_W-1:0] and go to ACC.
REQ-018 Magnitude SHALL be SAMPLE_W-bit unsigned |x|; -2^(SAMPLE_W-1) maps to 2^(SAMPLE_W-1) without wrap.
REQ-019 Mode 0 (SUM): acc += |x|, saturating at 2^ACC_W-1 and setting sticky ovf; mode 1 (PEAK): acc = max(acc, |x|).
REQ-020 ACC SHALL return to READ until NUM_CH*BLOCK_LEN samples done, then go to WR_LO.
REQ-021 WR_LO/WR_HI SHALL write acc[31:0] to DST_BASE+2b, then acc[ACC_W-1:32] zero-extended to DST_BASE+2b+1, each held until waitrequest low.
REQ-022 After WR_HI completes: BLOCKS_DONE++, acc cleared, then READ for next block or DONE after BLOCK_CNT blocks.
REQ-023 BLOCK_LEN=0 or BLOCK_CNT=0 at start SHALL go directly to DONE with cfg_err=1 and no bus traffic.
REQ-024 Abort SHALL take effect only after the current transfer completes (never drop read/write while waitrequest high), then DONE with aborted=1.
REQ-025 read and write SHALL never be high together; master outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-026 Reset SHALL put FSM in IDLE; DONE, avm read/write, STATUS, BLOCKS_DONE, acc, all config registers to 0, effective next edge even mid-transfer.
REQ-027 avs_avalonslave_readdata SHALL reset to 0.

Structure
REQ-028 Package magacc_pkg SHALL hold state encoding, register offsets, STATUS bit positions, mode codes.
REQ-029 Sub-module magacc_abs_acc SHALL implement abs, saturating sum and max; FSM, address generation and slave register file stay in the top.

Verification
REQ-030 NUM_CH=2, BLOCK_LEN=4, BLOCK_CNT=1, samples L={1,-2,3,-4} R={-5,6,-7,8}, mode 0 -> writes 36 then 0 at DST_BASE, DST_BASE+1; DONE=1.
REQ-031 Same data, mode 1 -> writes 8, 0; BLOCKS_DONE=1.
REQ-032 SAMPLE_W=16, sample 0x8000 -> magnitude 32768, no wrap.
REQ-033 BLOCK_CNT=3 with waitrequest randomly high 0-5 cycles -> six writes at DST_BASE..+5, address/data stable while stalled.
REQ-034 Abort mid-read with waitrequest high 3 cycles -> read held until accepted, then DONE, aborted=1; BLOCK_LEN=0 start -> DONE, cfg_err=1, no traffic.
REQ-035 Reset asserted during WR_LO stall -> write low next cycle, FSM IDLE, STATUS=0.

Source files
------------

// File: rtl/magacc_pkg.sv
// Shared encodings for the multichannel magnitude accelerator: FSM states,
// slave register offsets, STATUS bit positions and accumulate modes.
package magacc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ACC   = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int REG_CTRL        = 0;
  localparam int REG_STATUS      = 1;
  localparam int REG_SRC_BASE    = 2;
  localparam int REG_CH_STRIDE   = 3;
  localparam int REG_DST_BASE    = 4;
  localparam int REG_BLOCK_LEN   = 5;
  localparam int REG_BLOCK_CNT   = 6;
  localparam int REG_BLOCKS_DONE = 7;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_CFG_ERR = 4;

  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_PEAK = 1'b1;

endpackage

// File: rtl/magacc_abs_acc.sv
// Magnitude of one signed sample folded into the running accumulator,
// either as a saturating sum or as a running maximum.
module magacc_abs_acc
  import magacc_pkg::*;
#(
  parameter int SAMPLE_W = 32,
  parameter int ACC_W    = 64
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [ACC_W-1:0]    acc,
  input  logic                mode,
  output logic [ACC_W-1:0]    acc_next,
  output logic                ovf
);

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W:0]      sum;

  always_comb begin
    // Unsigned result: the most negative input lands on 2^(SAMPLE_W-1).
    mag = sample[SAMPLE_W-1] ? (~sample + SAMPLE_W'(1)) : sample;
    sum = {1'b0, acc} + (ACC_W+1)'(mag);
    ovf = 1'b0;
    if (mode == MODE_PEAK) begin
      acc_next = (ACC_W'(mag) > acc) ? ACC_W'(mag) : acc;
    end else if (sum[ACC_W]) begin
      acc_next = '1;
      ovf      = 1'b1;
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/multichannel_magnitude_accel.sv
// Avalon-MM accelerator: sums or peaks |x| over NUM_CH channel buffers per
// block and writes each block's accumulator as two words to DST_BASE.
module multichannel_magnitude_accel
  import magacc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 32,
  parameter int ACC_W      = 64,
  parameter int AVS_ADDR_W = 4,
  parameter int AVM_ADDR_W = 32
) (
  input  logic                  csi_clock_clk,
  input  logic                  csi_clock_reset_n,
  input  logic [AVS_ADDR_W-1:0] avs_avalonslave_address,
  input  logic                  avs_avalonslave_read,
  input  logic                  avs_avalonslave_write,
  input  logic [31:0]           avs_avalonslave_writedata,
  output logic [31:0]           avs_avalonslave_readdata,
  output logic [AVM_ADDR_W-1:0] avm_avalonmaster_address,
  output logic                  avm_avalonmaster_read,
  output logic                  avm_avalonmaster_write,
  output logic [31:0]           avm_avalonmaster_writedata,
  input  logic                  avm_avalonmaster_waitrequest,
  input  logic [31:0]           avm_avalonmaster_readdata,
  output logic                  DONE
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = AVM_ADDR_W;

  state_t              state;
  logic [31:0]         cfg_src, cfg_stride, cfg_dst, cfg_len, cfg_cnt;
  logic                cfg_mode;
  logic [AW-1:0]       w_stride, blk_base, smp_ptr, wr_addr;
  logic [31:0]         w_len, w_cnt, smp_idx, blk_idx, blocks_done;
  logic [CH_W-1:0]     ch_idx;
  logic                w_mode, done_r, ovf, aborted, cfg_err, abort_pend;
  logic [ACC_W-1:0]    acc, acc_next;
  logic                acc_ovf;
  logic [SAMPLE_W-1:0] sample;
  logic [63:0]         acc_ext, next_ext;
  logic [31:0]         status, rd_mux;
  logic                ctrl_wr, start_req, abort_req, busy, abort_hit;
  logic                last_ch, last_smp, last_blk, accepted;

  magacc_abs_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_abs_acc (
    .sample   (sample),
    .acc      (acc),
    .mode     (w_mode),
    .acc_next (acc_next),
    .ovf      (acc_ovf)
  );

  assign acc_ext   = 64'(acc);
  assign next_ext  = 64'(acc_next);
  assign ctrl_wr   = avs_avalonslave_write && (avs_avalonslave_address == AVS_ADDR_W'(REG_CTRL));
  assign start_req = ctrl_wr && avs_avalonslave_writedata[CTRL_START];
  assign abort_req = ctrl_wr && avs_avalonslave_writedata[CTRL_ABORT];
  assign busy      = (state == ST_READ) || (state == ST_ACC) || (state == ST_WR_LO) || (state == ST_WR_HI);
  assign abort_hit = abort_pend || abort_req;
  assign last_ch   = (ch_idx == CH_W'(NUM_CH - 1));
  assign last_smp  = (smp_idx == w_len - 32'd1);
  assign last_blk  = (blk_idx == w_cnt - 32'd1);
  assign accepted  = !avm_avalonmaster_waitrequest;
  assign DONE      = done_r;

  always_comb begin
    status               = '0;
    status[STAT_DONE]    = done_r;
    status[STAT_BUSY]    = busy;
    status[STAT_OVF]     = ovf;
    status[STAT_ABORTED] = aborted;
    status[STAT_CFG_ERR] = cfg_err;
    rd_mux = '0;
    case (avs_avalonslave_address)
      AVS_ADDR_W'(REG_CTRL):        rd_mux[CTRL_MODE] = cfg_mode;
      AVS_ADDR_W'(REG_STATUS):      rd_mux = status;
      AVS_ADDR_W'(REG_SRC_BASE):    rd_mux = cfg_src;
      AVS_ADDR_W'(REG_CH_STRIDE):   rd_mux = cfg_stride;
      AVS_ADDR_W'(REG_DST_BASE):    rd_mux = cfg_dst;
      AVS_ADDR_W'(REG_BLOCK_LEN):   rd_mux = cfg_len;
      AVS_ADDR_W'(REG_BLOCK_CNT):   rd_mux = cfg_cnt;
      AVS_ADDR_W'(REG_BLOCKS_DONE): rd_mux = blocks_done;
      default:                      rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_clock_clk) begin
    if (csi_clock_reset_n) begin
      state                      <= ST_IDLE;
      {cfg_src, cfg_stride, cfg_dst, cfg_len, cfg_cnt} <= '0;
      cfg_mode                   <= 1'b0;
      {w_stride, blk_base, smp_ptr, wr_addr} <= '0;
      {w_len, w_cnt, smp_idx, blk_idx, blocks_done} <= '0;
      ch_idx                     <= '0;
      {w_mode, done_r, ovf, aborted, cfg_err, abort_pend} <= '0;
      acc                        <= '0;
      sample                     <= '0;
      avs_avalonslave_readdata   <= '0;
      avm_avalonmaster_address   <= '0;
      avm_avalonmaster_read      <= 1'b0;
      avm_avalonmaster_write     <= 1'b0;
      avm_avalonmaster_writedata <= '0;
    end else begin
      if (avs_avalonslave_write) begin
        case (avs_avalonslave_address)
          AVS_ADDR_W'(REG_CTRL):      cfg_mode   <= avs_avalonslave_writedata[CTRL_MODE];
          AVS_ADDR_W'(REG_SRC_BASE):  cfg_src    <= avs_avalonslave_writedata;
          AVS_ADDR_W'(REG_CH_STRIDE): cfg_stride <= avs_avalonslave_writedata;
          AVS_ADDR_W'(REG_DST_BASE):  cfg_dst    <= avs_avalonslave_writedata;
          AVS_ADDR_W'(REG_BLOCK_LEN): cfg_len    <= avs_avalonslave_writedata;
          AVS_ADDR_W'(REG_BLOCK_CNT): cfg_cnt    <= avs_avalonslave_writedata;
          default: ;
        endcase
      end
      if (avs_avalonslave_read) avs_avalonslave_readdata <= rd_mux;
      // An abort only marks intent; each state retires it at a transfer boundary.
      if (busy && abort_req) abort_pend <= 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            {done_r, ovf, aborted, cfg_err, abort_pend} <= '0;
            blocks_done <= '0;
            acc         <= '0;
            w_mode      <= avs_avalonslave_writedata[CTRL_MODE];
            w_stride    <= AW'(cfg_stride);
            w_len       <= cfg_len;
            w_cnt       <= cfg_cnt;
            blk_base    <= AW'(cfg_src);
            smp_ptr     <= AW'(cfg_src);
            wr_addr     <= AW'(cfg_dst);
            ch_idx      <= '0;
            smp_idx     <= '0;
            blk_idx     <= '0;
            if (cfg_len == 32'd0 || cfg_cnt == 32'd0) begin
              cfg_err <= 1'b1;
              done_r  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              avm_avalonmaster_address <= AW'(cfg_src);
              avm_avalonmaster_read    <= 1'b1;
              state                    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (accepted) begin
            avm_avalonmaster_read <= 1'b0;
            sample                <= avm_avalonmaster_readdata[SAMPLE_W-1:0];
            if (abort_hit) begin
              avm_avalonmaster_address <= '0;
              {done_r, aborted}        <= 2'b11;
              abort_pend               <= 1'b0;
              state                    <= ST_DONE;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          acc <= acc_next;
          if (acc_ovf) ovf <= 1'b1;
          if (abort_hit) begin
            avm_avalonmaster_address <= '0;
            {done_r, aborted}        <= 2'b11;
            abort_pend               <= 1'b0;
            state                    <= ST_DONE;
          end else if (last_ch && last_smp) begin
            avm_avalonmaster_address   <= wr_addr;
            avm_avalonmaster_writedata <= next_ext[31:0];
            avm_avalonmaster_write     <= 1'b1;
            state                      <= ST_WR_LO;
          end else if (last_ch) begin
            ch_idx                   <= '0;
            smp_idx                  <= smp_idx + 32'd1;
            smp_ptr                  <= smp_ptr + AW'(1);
            avm_avalonmaster_address <= smp_ptr + AW'(1);
            avm_avalonmaster_read    <= 1'b1;
            state                    <= ST_READ;
          end else begin
            ch_idx                   <= ch_idx + CH_W'(1);
            avm_avalonmaster_address <= avm_avalonmaster_address + w_stride;
            avm_avalonmaster_read    <= 1'b1;
            state                    <= ST_READ;
          end
        end
        ST_WR_LO: begin
          if (accepted) begin
            if (abort_hit) begin
              avm_avalonmaster_write     <= 1'b0;
              avm_avalonmaster_address   <= '0;
              avm_avalonmaster_writedata <= '0;
              {done_r, aborted}          <= 2'b11;
              abort_pend                 <= 1'b0;
              state                      <= ST_DONE;
            end else begin
              avm_avalonmaster_address   <= avm_avalonmaster_address + AW'(1);
              avm_avalonmaster_writedata <= acc_ext[63:32];
              state                      <= ST_WR_HI;
            end
          end
        end
        ST_WR_HI: begin
          if (accepted) begin
            avm_avalonmaster_write     <= 1'b0;
            avm_avalonmaster_writedata <= '0;
            blocks_done                <= blocks_done + 32'd1;
            acc                        <= '0;
            wr_addr                    <= wr_addr + AW'(2);
            if (abort_hit || last_blk) begin
              avm_avalonmaster_address <= '0;
              done_r                   <= 1'b1;
              aborted                  <= abort_hit;
              abort_pend               <= 1'b0;
              state                    <= ST_DONE;
            end else begin
              blk_idx                  <= blk_idx + 32'd1;
              blk_base                 <= blk_base + AW'(w_len);
              smp_ptr                  <= blk_base + AW'(w_len);
              ch_idx                   <= '0;
              smp_idx                  <= '0;
              avm_avalonmaster_address <= blk_base + AW'(w_len);
              avm_avalonmaster_read    <= 1'b1;
              state                    <= ST_READ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
